pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Next-generation program counter for the single-cycle RISC-V core. It holds the
//  fetch PC and selects the next PC from five sources: sequential, stall-hold,
//  branch/jump redirect, trap vector, and return prediction from an internal
//  return-address stack (RAS). It sits between the control unit / branch logic and
//  the instruction memory address port.
// PARAMETERS
//  N            32           PC width in bits
//  RESET_VECTOR 32'h0000_0000 PC value loaded on reset
//  ALIGN        2            number of low PC bits forced to zero (2 = 4-byte)
//  RAS_DEPTH    4            RAS entries; must be a power of 2, >= 2
//  FLUSH_ON_TRAP 1           1 = trap empties the RAS
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  stall           in   1   hold PC (sequential, pop and push are suppressed)
//  redirect_valid  in   1   branch taken / jump: load redirect_target
//  redirect_target in   N   redirect destination
//  trap_valid      in   1   exception/interrupt: load trap_vec
//  trap_vec        in   N   trap handler address
//  ras_push        in   1   current instruction is a call: push pc_plus4
//  ras_pop         in   1   current instruction is a return: next PC = RAS top
//  pc              out  N   current fetch address
//  pc_plus4        out  N   pc + 4, modulo 2^N
//  ras_empty       out  1   RAS count == 0
//  ras_full        out  1   RAS count == RAS_DEPTH
//  misaligned      out  1   registered one-cycle pulse: last loaded target had nonzero low ALIGN bits
// BEHAVIOUR
//  - Reset (async assert, sync effect on release): pc=RESET_VECTOR, RAS count=0,
//    pointer=0, misaligned=0, ras_empty=1, ras_full=0. Reset mid-operation discards all state.
//  - Next-PC priority at each rising edge, highest first:
//    1 trap_valid -> trap_vec; 2 redirect_valid -> redirect_target (both override stall);
//    3 stall -> hold pc; 4 ras_pop & !ras_empty -> RAS top; 5 otherwise pc_plus4.
//  - ras_pop while empty: no pop, PC goes sequential (pc_plus4); no error flag.
//  - Latency: selected next PC appears on pc one edge later; pc_plus4 is combinational.
//  - Targets (trap/redirect/RAS) are loaded with low ALIGN bits cleared; misaligned is
//    set for exactly one cycle after loading a trap/redirect target whose low bits were nonzero.
//  - RAS: circular buffer, top pointer and count register.
//    Push (when !stall and no trap): write pc_plus4 at top+1, top++, count=min(count+1,DEPTH).
//    Push when full overwrites the oldest entry (pointer wraps, count stays DEPTH).
//    Pop (when !stall, no trap, no redirect, !empty): top--, count--.
//    Push and pop in the same cycle: top entry replaced by pc_plus4; count and pointer unchanged.
//    Pop value is read before a same-cycle write.
//  - Trap: when FLUSH_ON_TRAP=1, count=0 (entries are not cleared); any same-cycle push/pop is ignored.
//    When FLUSH_ON_TRAP=0, the RAS is untouched and same-cycle push/pop are ignored.
//  - Redirect with ras_push (JAL/JALR call): the push happens and the PC takes redirect_target.
//  - All arithmetic wraps modulo 2^N; pointer wraps modulo RAS_DEPTH.
// STRUCTURE
//  - pc_pkg: next-PC source enum (SRC_TRAP, SRC_REDIR, SRC_HOLD, SRC_RAS, SRC_SEQ),
//    INSTR_BYTES=4 constant, align-mask function.
//  - Sub-module ras_stack (params N, RAS_DEPTH): push/pop/flush inputs; top, empty and full outputs.
//  - pc_unit holds the PC register, priority mux, alignment and misaligned register.
// TESTING
//  1 Assert reset mid-cycle with pc=0x40 -> pc=0x0 immediately; release, 3 clocks -> 0x4, 0x8, 0xC.
//  2 stall=1 at pc=0x10 for 2 cycles -> pc holds 0x10; redirect 0x80 with stall -> pc=0x80 next edge.
//  3 Push at pc=0x20 with redirect 0x100, then pop at 0x104 -> pc=0x24, ras_empty=1 afterward.
//  4 With RAS_DEPTH=4, 5 pushes (pc_plus4 = A..E), then 4 pops -> E, D, C, B; 5th pop -> sequential; ras_full seen after 4th push.
//  5 Trap 0x200 with redirect 0x300, pop and push in the same cycle -> pc=0x200, ras_empty=1, no push.
//  6 Redirect 0x102 -> pc=0x100 and misaligned=1 for exactly one cycle; push+pop same cycle -> count unchanged, top=pc_plus4.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the program counter unit
// Purpose: next-PC source encoding, instruction size and alignment mask helper.
// Ports: none (package).
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_REDIR,
        SRC_HOLD,
        SRC_RAS,
        SRC_SEQ
    } next_src_e;

    localparam int INSTR_BYTES = 4;

    // Mask that clears the low 'align' bits; callers truncate to their PC width.
    function automatic logic [63:0] align_mask(input int align);
        return ~((64'd1 << align) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/fetch side bundle of the program counter unit
// Purpose: groups next-PC control inputs and PC/RAS status outputs.
// Ports: master = control unit / branch logic side, slave = pc_unit.
interface pc_unit_if #(parameter int N = 32);

    logic         stall;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic         trap_valid;
    logic [N-1:0] trap_vec;
    logic         ras_push;
    logic         ras_pop;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         ras_empty;
    logic         ras_full;
    logic         misaligned;

    modport master (
        output stall, redirect_valid, redirect_target, trap_valid, trap_vec,
        output ras_push, ras_pop,
        input  pc, pc_plus4, ras_empty, ras_full, misaligned
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_valid, trap_vec,
        input  ras_push, ras_pop,
        output pc, pc_plus4, ras_empty, ras_full, misaligned
    );

endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack
// Purpose: holds return addresses; push writes above top, pop drops top.
// Ports: clk, reset (async high), push, pop, flush, wdata in;
//        top (current top entry), empty, full out.
module ras_stack #(
    parameter int N         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [N-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic          pop_ok;
    logic          we;
    logic [PW-1:0] waddr;

    assign empty  = (count == '0);
    assign full   = (count == CW'(RAS_DEPTH));
    assign pop_ok = pop & ~empty;
    assign top    = mem[ptr];

    // Push+pop together replaces the top entry in place.
    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        if (!flush && push) begin
            we    = 1'b1;
            waddr = pop_ok ? ptr : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop_ok) begin
            ptr <= ptr + PW'(1);
            // Full push overwrites the oldest entry; count saturates.
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop_ok && !push) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entries carry no reset: a zero count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with priority next-PC select and RAS
// Purpose: holds the fetch PC, picks trap/redirect/hold/RAS/sequential next PC,
//          aligns loaded targets and flags misaligned trap/redirect targets.
// Ports: clk, reset (async high); bus (pc_unit_if.slave) carries stall,
//        redirect, trap, ras_push/ras_pop in and pc, pc_plus4, ras_empty,
//        ras_full, misaligned out.
module pc_unit
    import pc_pkg::*;
#(
    parameter int           N             = 32,
    parameter logic [N-1:0] RESET_VECTOR  = '0,
    parameter int           ALIGN         = 2,
    parameter int           RAS_DEPTH     = 4,
    parameter int           FLUSH_ON_TRAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    localparam logic [N-1:0] MASK = N'(align_mask(ALIGN));

    next_src_e    src;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_next;
    logic [N-1:0] plus4;
    logic [N-1:0] ras_top;
    logic         ras_empty;
    logic         ras_full;
    logic         do_push;
    logic         do_pop;
    logic         flush;
    logic         misaligned_q;
    logic         misaligned_d;

    assign plus4 = pc_q + N'(INSTR_BYTES);

    always_comb begin
        src = SRC_SEQ;
        if (bus.trap_valid) begin
            src = SRC_TRAP;
        end else if (bus.redirect_valid) begin
            src = SRC_REDIR;
        end else if (bus.stall) begin
            src = SRC_HOLD;
        end else if (bus.ras_pop && !ras_empty) begin
            src = SRC_RAS;
        end
    end

    always_comb begin
        pc_next      = plus4;
        misaligned_d = 1'b0;
        case (src)
            SRC_TRAP: begin
                pc_next      = bus.trap_vec & MASK;
                misaligned_d = |(bus.trap_vec & ~MASK);
            end
            SRC_REDIR: begin
                pc_next      = bus.redirect_target & MASK;
                misaligned_d = |(bus.redirect_target & ~MASK);
            end
            SRC_HOLD: pc_next = pc_q;
            SRC_RAS:  pc_next = ras_top & MASK;
            default:  pc_next = plus4;
        endcase
    end

    // A call that is also a redirect (JAL/JALR) still pushes; pops only on the RAS path.
    assign do_push = bus.ras_push & ~bus.stall & ~bus.trap_valid;
    assign do_pop  = (src == SRC_RAS);
    assign flush   = bus.trap_valid & (FLUSH_ON_TRAP != 0);

    ras_stack #(
        .N         (N),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .flush (flush),
        .wdata (plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_next;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = plus4;
    assign bus.ras_empty  = ras_empty;
    assign bus.ras_full   = ras_full;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit
module tb_pc_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pc_unit_if #(.N(32)) bus ();

    pc_unit #(
        .N             (32),
        .RESET_VECTOR  (32'h0000_0000),
        .ALIGN         (2),
        .RAS_DEPTH     (4),
        .FLUSH_ON_TRAP (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic idle();
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.trap_valid      = 1'b0;
        bus.trap_vec        = '0;
        bus.ras_push        = 1'b0;
        bus.ras_pop         = 1'b0;
    endtask

    // Expected PC is queued with the stimulus, popped once the edge has taken effect.
    task automatic cycle(input string tag, input logic [31:0] exp_pc);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp_pc);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, bus.pc, e);
        chk({t, "_p4"}, bus.pc_plus4, e + 32'd4);
        idle();
    endtask

    initial begin
        idle();
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk_bit("rst_empty", bus.ras_empty, 1'b1);
        chk_bit("rst_full", bus.ras_full, 1'b0);
        chk_bit("rst_mis", bus.misaligned, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1: run to 0x40, reset mid-cycle, then sequential from 0
        for (int i = 1; i <= 16; i++) cycle("seq_run", 32'(i * 4));
        #2 reset = 1'b1;
        #1 chk("async_rst_pc", bus.pc, 32'h0);
        #1 reset = 1'b0;
        cycle("post_rst_4", 32'h4);
        cycle("post_rst_8", 32'h8);
        cycle("post_rst_c", 32'hC);
        cycle("seq_10", 32'h10);

        // 2: stall hold, redirect overrides stall
        bus.stall = 1'b1; cycle("stall_1", 32'h10);
        bus.stall = 1'b1; cycle("stall_2", 32'h10);
        bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h80;
        cycle("redir_stall", 32'h80);

        // 3: call via redirect, return pops pc_plus4 of the call
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h20; cycle("to_20", 32'h20);
        bus.ras_push = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
        cycle("call_redir", 32'h100);
        chk_bit("call_nonempty", bus.ras_empty, 1'b0);
        cycle("seq_104", 32'h104);
        bus.ras_pop = 1'b1; cycle("ret_24", 32'h24);
        chk_bit("ret_empty", bus.ras_empty, 1'b1);

        // 4: five pushes into depth 4, oldest overwritten
        bus.ras_push = 1'b1; cycle("push_a", 32'h28);
        bus.ras_push = 1'b1; cycle("push_b", 32'h2C);
        bus.ras_push = 1'b1; cycle("push_c", 32'h30);
        chk_bit("full_after_3", bus.ras_full, 1'b0);
        bus.ras_push = 1'b1; cycle("push_d", 32'h34);
        chk_bit("full_after_4", bus.ras_full, 1'b1);
        bus.ras_push = 1'b1; cycle("push_e", 32'h38);
        chk_bit("full_after_5", bus.ras_full, 1'b1);
        bus.ras_pop = 1'b1; cycle("pop_e", 32'h38);
        chk_bit("full_after_pop", bus.ras_full, 1'b0);
        bus.ras_pop = 1'b1; cycle("pop_d", 32'h34);
        bus.ras_pop = 1'b1; cycle("pop_c", 32'h30);
        bus.ras_pop = 1'b1; cycle("pop_b", 32'h2C);
        chk_bit("empty_after_4_pops", bus.ras_empty, 1'b1);
        bus.ras_pop = 1'b1; cycle("pop_empty_seq", 32'h30);

        // 5: trap beats redirect/push/pop and flushes the RAS
        bus.ras_push = 1'b1; cycle("push_pre_trap", 32'h34);
        chk_bit("pre_trap_nonempty", bus.ras_empty, 1'b0);
        bus.trap_valid = 1'b1; bus.trap_vec = 32'h200;
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h300;
        bus.ras_push = 1'b1; bus.ras_pop = 1'b1;
        cycle("trap_200", 32'h200);
        chk_bit("trap_flush_empty", bus.ras_empty, 1'b1);
        chk_bit("trap_mis", bus.misaligned, 1'b0);
        cycle("after_trap", 32'h204);
        chk_bit("after_trap_empty", bus.ras_empty, 1'b1);

        // 6: misaligned targets, then push+pop in the same cycle
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h102; cycle("redir_102", 32'h100);
        chk_bit("mis_pulse", bus.misaligned, 1'b1);
        cycle("seq_after_mis", 32'h104);
        chk_bit("mis_clear", bus.misaligned, 1'b0);
        bus.trap_valid = 1'b1; bus.trap_vec = 32'h203; cycle("trap_203", 32'h200);
        chk_bit("trap_mis_pulse", bus.misaligned, 1'b1);
        cycle("seq_204", 32'h204);
        bus.ras_push = 1'b1; cycle("push_208", 32'h208);
        bus.ras_push = 1'b1; bus.ras_pop = 1'b1; cycle("pushpop_old_top", 32'h208);
        chk_bit("pushpop_nonempty", bus.ras_empty, 1'b0);
        bus.ras_pop = 1'b1; cycle("pop_new_top", 32'h20C);
        chk_bit("pushpop_count_kept", bus.ras_empty, 1'b1);

        // pc_plus4 wraps modulo 2^32
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC; cycle("wrap_top", 32'hFFFF_FFFC);
        cycle("wrap_zero", 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
